demux_64_collect: RTL and testbench

DEMUX_64_COLLECT -- requirements
Module: demux_64_collect

---
 rtl/demux_64_collect.sv | 121 ++++++++++++
 tb/tb_demux_64_collect.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_64_collect.sv
// demux_64_collect: scatters single data bits into a 64-bit word by index and emits
// the assembled word together with a mask of the indices that were written.
//
// Parameters:
//   AUTO_FLUSH  1: close the word as soon as all 64 mask bits are set
//               0: close the word only on in_last
// Optional feature (compile-time macro DEMUX_64_COLLECT_PARITY_EN):
//   adds out_parity = XOR of out_data, registered, reset to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready is high only while filling
//   in_sel, in_bit      destination index and data bit
//   in_last             closes the current word after this bit
//   out_valid/out_ready output handshake; out_valid is high only while holding a word
//   out_data, out_mask  assembled word and written-index mask
//   out_dup             sticky flag: some index was written twice in this word
module demux_64_collect #(
  parameter int unsigned AUTO_FLUSH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_sel,
  input  logic        in_bit,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [63:0] out_mask,
  output logic        out_dup
`ifdef DEMUX_64_COLLECT_PARITY_EN
  ,
  output logic        out_parity
`endif
);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e      state_q;
  logic [63:0] data_q;
  logic [63:0] mask_q;
  logic        dup_q;
  logic        valid_q;
  logic        ready_q;

  logic [63:0] data_upd;
  logic [63:0] mask_upd;
  logic        close_word;

  // Word contents as they would look after accepting the offered bit.
  always_comb begin
    data_upd         = data_q;
    data_upd[in_sel] = in_bit;
    mask_upd         = mask_q;
    mask_upd[in_sel] = 1'b1;
    close_word       = in_last || ((AUTO_FLUSH != 0) && (&mask_upd));
  end

`ifdef DEMUX_64_COLLECT_PARITY_EN
  logic parity_q;
  assign out_parity = parity_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFill;
      data_q   <= '0;
      mask_q   <= '0;
      dup_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
`ifdef DEMUX_64_COLLECT_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StFill: begin
          if (in_valid) begin
            data_q <= data_upd;
            mask_q <= mask_upd;
            if (mask_q[in_sel]) begin
              dup_q <= 1'b1;
            end
`ifdef DEMUX_64_COLLECT_PARITY_EN
            parity_q <= ^data_upd;
`endif
            if (close_word) begin
              state_q <= StHold;
              valid_q <= 1'b1;
              ready_q <= 1'b0;
            end
          end
        end
        StHold: begin
          // Word is frozen until the consumer takes it; then start an empty word.
          if (out_ready) begin
            state_q  <= StFill;
            data_q   <= '0;
            mask_q   <= '0;
            dup_q    <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
`ifdef DEMUX_64_COLLECT_PARITY_EN
            parity_q <= 1'b0;
`endif
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_mask  = mask_q;
  assign out_dup   = dup_q;

endmodule

// File: tb/tb_demux_64_collect.sv
// Bench for demux_64_collect: two instances (AUTO_FLUSH=1 and AUTO_FLUSH=0) share the same
// stimulus; a word-level reference model is kept for each and compared every cycle,
// with extra constant checks on the directed scenarios.
module tb_demux_64_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  in_sel;
  logic        in_bit;
  logic        in_last;
  logic        out_ready;

  logic        rdy0, vld0, dup0, rdy1, vld1, dup1;
  logic [63:0] dat0, msk0, dat1, msk1;
  logic        par0, par1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: index 0 = AUTO_FLUSH on, index 1 = AUTO_FLUSH off.
  logic [63:0] m_data [2];
  logic [63:0] m_mask [2];
  logic        m_dup  [2];
  logic        m_hold [2];

  always #5 clk = ~clk;

  demux_64_collect #(.AUTO_FLUSH(1)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (rdy0),
    .in_sel    (in_sel),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (vld0),
    .out_ready (out_ready),
    .out_data  (dat0),
    .out_mask  (msk0),
    .out_dup   (dup0)
`ifdef DEMUX_64_COLLECT_PARITY_EN
    ,
    .out_parity(par0)
`endif
  );

  demux_64_collect #(.AUTO_FLUSH(0)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (rdy1),
    .in_sel    (in_sel),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (vld1),
    .out_ready (out_ready),
    .out_data  (dat1),
    .out_mask  (msk1),
    .out_dup   (dup1)
`ifdef DEMUX_64_COLLECT_PARITY_EN
    ,
    .out_parity(par1)
`endif
  );

`ifndef DEMUX_64_COLLECT_PARITY_EN
  assign par0 = 1'b0;
  assign par1 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic vld, input logic rdy, input logic [63:0] dat,
                          input logic [63:0] msk, input logic dup, input logic par);
    string p;
    p = (i == 0) ? "af1" : "af0";
    chk({p, "_out_valid"}, 64'(vld), 64'(m_hold[i]));
    chk({p, "_in_ready"}, 64'(rdy), 64'(!m_hold[i]));
    chk({p, "_out_data"}, dat, m_data[i]);
    chk({p, "_out_mask"}, msk, m_mask[i]);
    chk({p, "_out_dup"}, 64'(dup), 64'(m_dup[i]));
`ifdef DEMUX_64_COLLECT_PARITY_EN
    chk({p, "_out_parity"}, 64'(par), 64'(^m_data[i]));
`else
    if (par !== 1'b0) chk({p, "_par_tie"}, 64'(par), 64'd0);
`endif
  endtask

  // One clock: drive inputs, advance the model, then compare #1 after the edge.
  task automatic step(input logic v, input logic [5:0] s, input logic b, input logic l,
                      input logic r, input logic rs);
    in_valid  = v;
    in_sel    = s;
    in_bit    = b;
    in_last   = l;
    out_ready = r;
    rst       = rs;
    for (int i = 0; i < 2; i++) begin
      if (rs) begin
        m_data[i] = '0;
        m_mask[i] = '0;
        m_dup[i]  = 1'b0;
        m_hold[i] = 1'b0;
      end else if (!m_hold[i]) begin
        if (v) begin
          if (m_mask[i][s]) m_dup[i] = 1'b1;
          m_data[i][s] = b;
          m_mask[i][s] = 1'b1;
          if (l || (i == 0 && m_mask[i] == {64{1'b1}})) m_hold[i] = 1'b1;
        end
      end else if (r) begin
        m_data[i] = '0;
        m_mask[i] = '0;
        m_dup[i]  = 1'b0;
        m_hold[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cmp_inst(0, vld0, rdy0, dat0, msk0, dup0, par0);
    cmp_inst(1, vld1, rdy1, dat1, msk1, dup1, par1);
  endtask

  initial begin
    logic [5:0] s;
    for (int i = 0; i < 2; i++) begin
      m_data[i] = 'x;
      m_mask[i] = 'x;
      m_dup[i]  = 1'bx;
      m_hold[i] = 1'bx;
    end
    in_valid = 0; in_sel = 0; in_bit = 0; in_last = 0; out_ready = 0; rst = 1;

    // Reset
    step(1, 6'd3, 1, 1, 1, 1);
    step(0, 6'd0, 0, 0, 0, 1);
    step(0, 6'd0, 0, 0, 0, 0);

    // 64 accepts sel 0..63, bit = sel[0]
    for (int k = 0; k < 64; k++) begin
      s = 6'(k);
      step(1, s, s[0], 0, 0, 0);
      if (k < 63) chk("fill_no_early_valid", 64'(vld0), 64'd0);
    end
    chk("full_valid", 64'(vld0), 64'd1);
    chk("full_data", dat0, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("full_mask", msk0, {64{1'b1}});
    chk("full_dup", 64'(dup0), 64'd0);
    chk("noflush_no_emit", 64'(vld1), 64'd0);

    // Hold for 10 cycles with in_valid high, consumer not ready
    for (int k = 0; k < 10; k++) begin
      step(1, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
      chk("hold_ready_low", 64'(rdy0), 64'd0);
      chk("hold_data_stable", dat0, 64'hAAAA_AAAA_AAAA_AAAA);
    end
    // With in_last random above, af0 instance may be holding too; release both.
    step(0, 6'd0, 0, 0, 1, 0);
    chk("release_valid", 64'(vld0), 64'd0);
    chk("release_mask", msk0, 64'd0);
    chk("release_ready", 64'(rdy0), 64'd1);

    // Fresh word for af1; for af0 force the "full mask then last" case
    step(0, 6'd0, 0, 0, 0, 1);
    for (int k = 0; k < 64; k++) step(1, 6'(k), 1'($urandom_range(0, 1)), 0, 0, 0);
    step(0, 6'd0, 0, 0, 1, 0);  // af1 released; out_ready ignored by af0 while filling
    chk("noflush_still_filling", 64'(vld1), 64'd0);
    step(1, 6'd7, 1, 1, 0, 0);
    chk("single_bit_mask", msk0, 64'h80);
    chk("single_bit_valid", 64'(vld0), 64'd1);
    chk("noflush_last_emit", 64'(vld1), 64'd1);
    chk("noflush_last_dup", 64'(dup1), 64'd1);
    step(0, 6'd0, 0, 0, 1, 0);

    // Duplicate index within a word
    step(1, 6'd5, 1, 0, 0, 0);
    step(1, 6'd5, 0, 0, 0, 0);
    step(1, 6'd9, 1, 1, 0, 0);
    chk("dup_data", dat0, 64'h200);
    chk("dup_mask", msk0, 64'h220);
    chk("dup_flag", 64'(dup0), 64'd1);
    step(0, 6'd0, 0, 0, 1, 0);

    // Parity words 0x1 and 0x3
    step(1, 6'd0, 1, 1, 0, 0);
    chk("par_word1", dat0, 64'h1);
`ifdef DEMUX_64_COLLECT_PARITY_EN
    chk("par1", 64'(par0), 64'd1);
`endif
    step(0, 6'd0, 0, 0, 1, 0);
    step(1, 6'd0, 1, 0, 0, 0);
    step(1, 6'd1, 1, 1, 0, 0);
    chk("par_word3", dat0, 64'h3);
`ifdef DEMUX_64_COLLECT_PARITY_EN
    chk("par0", 64'(par0), 64'd0);
`endif
    step(0, 6'd0, 0, 0, 1, 0);

    // Reset mid-fill, then a clean 64-bit word
    for (int k = 0; k < 30; k++) step(1, 6'(k), 1'($urandom_range(0, 1)), 0, 0, 0);
    step(1, 6'd40, 1, 1, 1, 1);
    chk("midrst_mask", msk0, 64'd0);
    chk("midrst_ready", 64'(rdy0), 64'd1);
    for (int k = 0; k < 64; k++) step(1, 6'(63 - k), 1'($urandom_range(0, 1)), 0, 0, 0);
    chk("clean_mask", msk0, {64{1'b1}});
    chk("clean_dup", 64'(dup0), 64'd0);
    // Reset while holding
    step(0, 6'd0, 0, 0, 1, 1);
    chk("holdrst_valid", 64'(vld0), 64'd0);

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
